// File: rtl/seg7_scan_ctrl.sv
// Scan controller time-multiplexing one registered 7-segment decoder across
// NUM_DIGITS digits, with a per-digit value file, dwell period and blank gap.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int IDX_W      = 2,
   parameter int DWELL      = 1000,
   parameter int BLANK      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_val,
   output logic [3:0]            dec_val,
   output logic [NUM_DIGITS-1:0] dig_en,
   output logic                  frame_tick
);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_next;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       digit [NUM_DIGITS];
   logic [3:0]       val_next;

   // The digit being prepared or lit is locked so the decoder never sees it change.
   assign wr_ready = !(((state == S_SETUP) || (state == S_SHOW)) && (wr_idx == ptr));

   always_comb begin
      ptr_next = (ptr == PTR_LAST) ? '0 : ptr + IDX_W'(1);
      val_next = digit[0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ptr_next == IDX_W'(i)) val_next = digit[i];
      end
   end

   // NOTE: this small register file is explicitly reset, so it is built from flops, not RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 4'h0;
      end else if (wr_valid && wr_ready) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_idx == IDX_W'(i)) digit[i] <= wr_val;
         end
      end
   end

   // NOTE: val_next samples pre-edge register contents, so a write landing on
   // the advance edge shows up only on the following frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_OFF;
         ptr        <= '0;
         cnt        <= '0;
         dec_val    <= 4'h0;
         dig_en     <= '0;
         frame_tick <= 1'b0;
      end else if (!en) begin
         state      <= S_OFF;
         ptr        <= '0;
         cnt        <= '0;
         dig_en     <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         case (state)
            S_OFF: begin
               ptr     <= '0;
               cnt     <= '0;
               dec_val <= digit[0];
               state   <= S_SETUP;
            end
            S_SETUP: begin
               dig_en <= NUM_DIGITS'(1) << ptr;
               cnt    <= '0;
               state  <= S_SHOW;
            end
            S_SHOW: begin
               if (cnt == DWELL_LAST) begin
                  dig_en <= '0;
                  cnt    <= '0;
                  if (BLANK > 0) begin
                     state <= S_GAP;
                  end else begin
                     ptr        <= ptr_next;
                     dec_val    <= val_next;
                     frame_tick <= (ptr == PTR_LAST);
                     state      <= S_SETUP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               if (cnt == BLANK_LAST) begin
                  cnt        <= '0;
                  ptr        <= ptr_next;
                  dec_val    <= val_next;
                  frame_tick <= (ptr == PTR_LAST);
                  state      <= S_SETUP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: a BLANK=2 four-digit instance and a
// BLANK=0 three-digit instance, table-driven scans plus corner sequences.
module tb_seg7_scan_ctrl;

   typedef struct {
      logic       en;
      logic [3:0] dig_en;
      logic [3:0] dec_val;
      logic       ft;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   int         n_cmp = 0;
   int         n_bad = 0;

   // Main instance: NUM_DIGITS=4, DWELL=3, BLANK=2
   logic       en, wr_valid, wr_ready, frame_tick;
   logic [1:0] wr_idx;
   logic [3:0] wr_val, dec_val, dig_en;

   // Second instance: NUM_DIGITS=3, DWELL=3, BLANK=0
   logic       en_b, wr_valid_b, wr_ready_b, frame_tick_b;
   logic [1:0] wr_idx_b;
   logic [3:0] wr_val_b, dec_val_b;
   logic [2:0] dig_en_b;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .IDX_W(2), .DWELL(3), .BLANK(2)) u_dut (
      .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_idx(wr_idx), .wr_val(wr_val), .dec_val(dec_val), .dig_en(dig_en),
      .frame_tick(frame_tick)
   );

   seg7_scan_ctrl #(.NUM_DIGITS(3), .IDX_W(2), .DWELL(3), .BLANK(0)) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
      .wr_idx(wr_idx_b), .wr_val(wr_val_b), .dec_val(dec_val_b), .dig_en(dig_en_b),
      .frame_tick(frame_tick_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_main(input logic [3:0] pat, input string name);
      int n = 0;
      while (dig_en !== pat && n < 100) begin
         step();
         n++;
      end
      if (dig_en !== pat) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: timeout waiting for dig_en=%b, got %b", name, pat, dig_en);
      end
   endtask

   initial begin
      vec_t       vecs[$];
      vec_t       bvecs[$];
      logic [3:0] bvals [3];
      logic [3:0] exp_show [4];
      logic       lit;
      int         n;

      rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_val = '0;
      en_b = 1'b0; wr_valid_b = 1'b0; wr_idx_b = '0; wr_val_b = '0;
      bvals    = '{4'hC, 4'h2, 4'h8};
      exp_show = '{4'h1, 4'h7, 4'h9, 4'h5};

      // Expected basic scan: per digit 1 SETUP, 3 SHOW, 2 GAP cycles
      for (int k = 0; k < 4; k++) begin
         vecs.push_back('{1'b1, 4'b0000, 4'(k + 1), 1'b0});
         for (int j = 0; j < 3; j++) vecs.push_back('{1'b1, 4'(1 << k), 4'(k + 1), 1'b0});
         for (int j = 0; j < 2; j++) vecs.push_back('{1'b1, 4'b0000, 4'(k + 1), 1'b0});
      end
      vecs.push_back('{1'b1, 4'b0000, 4'h1, 1'b1});
      vecs.push_back('{1'b1, 4'b0001, 4'h1, 1'b0});

      // BLANK=0 scan: 1 SETUP, 3 SHOW per digit
      for (int k = 0; k < 3; k++) begin
         bvecs.push_back('{1'b1, 4'b0000, bvals[k], 1'b0});
         for (int j = 0; j < 3; j++) bvecs.push_back('{1'b1, 4'(1 << k), bvals[k], 1'b0});
      end
      bvecs.push_back('{1'b1, 4'b0000, 4'hC, 1'b1});
      bvecs.push_back('{1'b1, 4'b0001, 4'hC, 1'b0});

      repeat (3) step();
      check("rst dig_en", dig_en, 0);
      check("rst dec_val", dec_val, 0);
      check("rst frame_tick", frame_tick, 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_idx = 2'(i); wr_val = 4'(i + 1);
         #1;
         check($sformatf("off wr_ready idx%0d", i), wr_ready, 1);
         step();
      end
      wr_valid = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         en = vecs[i].en;
         step();
         check($sformatf("scan%0d dig_en", i), dig_en, vecs[i].dig_en);
         check($sformatf("scan%0d dec_val", i), dec_val, vecs[i].dec_val);
         check($sformatf("scan%0d frame_tick", i), frame_tick, vecs[i].ft);
      end

      // Write stall on the lit digit, other digit accepted at once
      wait_main(4'b0100, "wait d2 show");
      wr_valid = 1'b1; wr_idx = 2'd2; wr_val = 4'h9;
      #1;
      check("stall lit digit", wr_ready, 0);
      wr_idx = 2'd1; wr_val = 4'h7;
      #1;
      check("other digit ready", wr_ready, 1);
      step();
      wr_idx = 2'd2; wr_val = 4'h9;
      n = 0;
      #1;
      while (!wr_ready && n < 20) begin
         step();
         n++;
      end
      check("stall cycles", n, 2);
      check("stall released in gap", dig_en, 0);
      step();
      wr_valid = 1'b0;
      check("dec_val held in gap", dec_val, 4'h3);
      wait_main(4'b0010, "wait d1 next frame");
      check("digit1 new value", dec_val, 4'h7);
      wait_main(4'b0100, "wait d2 next frame");
      check("digit2 new value", dec_val, 4'h9);

      // Write on the very edge that advances to that digit: old value shown
      repeat (4) step();
      wr_valid = 1'b1; wr_idx = 2'd3; wr_val = 4'h5;
      #1;
      check("advance-edge wr_ready", wr_ready, 1);
      step();
      wr_valid = 1'b0;
      check("advance-edge old value", dec_val, 4'h4);
      check("advance-edge setup dark", dig_en, 0);
      wait_main(4'b0001, "wait d0 next frame");
      wait_main(4'b1000, "wait d3 next frame");
      check("digit3 new value", dec_val, 4'h5);

      // Enable drop during the gap of digit 1
      wait_main(4'b0010, "wait d1 for en drop");
      repeat (3) step();
      check("in gap d1", dig_en, 0);
      en = 1'b0;
      step();
      check("en drop dig_en", dig_en, 0);
      check("en drop frame_tick", frame_tick, 0);
      check("en drop dec_val held", dec_val, 4'h7);
      lit = 1'b0;
      repeat (50) begin
         step();
         if (dig_en !== 4'b0000) lit = 1'b1;
      end
      check("off hold 50 dark", lit, 0);
      en = 1'b1;
      step();
      check("restart dec_val", dec_val, 4'h1);
      check("restart dark", dig_en, 0);
      check("restart no tick", frame_tick, 0);
      step();
      check("restart d0 lit", dig_en, 4'b0001);
      for (int k = 1; k < 4; k++) begin
         wait_main(4'(1 << k), $sformatf("wait d%0d after restart", k));
         check($sformatf("retained digit%0d", k), dec_val, exp_show[k]);
      end

      // Asynchronous reset in the middle of digit 2's dwell
      wait_main(4'b0100, "wait d2 for reset");
      #3;
      rst = 1'b1;
      #1;
      check("async rst dig_en", dig_en, 0);
      check("async rst dec_val", dec_val, 0);
      check("async rst frame_tick", frame_tick, 0);
      step();
      rst = 1'b0;
      step();
      check("post-rst digit0 cleared", dec_val, 4'h0);
      en = 1'b0;

      // BLANK=0 instance: dash value, out-of-range index discarded
      for (int i = 0; i < 4; i++) begin
         wr_valid_b = 1'b1; wr_idx_b = 2'(i); wr_val_b = (i < 3) ? bvals[i] : 4'h6;
         #1;
         check($sformatf("b wr_ready idx%0d", i), wr_ready_b, 1);
         step();
      end
      wr_valid_b = 1'b0;
      for (int i = 0; i < bvecs.size(); i++) begin
         en_b = bvecs[i].en;
         step();
         check($sformatf("b scan%0d dig_en", i), {1'b0, dig_en_b}, bvecs[i].dig_en);
         check($sformatf("b scan%0d dec_val", i), dec_val_b, bvecs[i].dec_val);
         check($sformatf("b scan%0d frame_tick", i), frame_tick_b, bvecs[i].ft);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
